// File: rtl/bsg_activation_pkg.sv
// Shared types for the activation datapath.
// FSM states and derivative-select encoding.
package bsg_activation_pkg;

    typedef enum {
        e_IDLE,
        e_SQ,
        e_DERIV,
        e_SCALE,
        e_DONE
    } bsg_act_bwd_state_e;

    typedef enum logic {
        e_sigmoid = 1'b0,
        e_tanh    = 1'b1
    } bsg_act_sel_e;

endpackage

// File: rtl/bsg_activation_backward_counter.sv
// Up counter with synchronous clear.
// Clear wins over increment.
module bsg_counter_clear_up #(
    parameter int max_val_p = 11,
    parameter int width_p   = $clog2(max_val_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q, count_d;

    // next count: clear, step or hold
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (up_i) begin
            count_d = count_q + width_p'(1);
        end
    end

    // count register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bsg_activation_backward_mul.sv
// Unsigned iterative shift-add multiplier.
// Bit 0 of b is consumed on the start edge; product held until next start.
module bsg_mul_iter_shift_add #(
    parameter int a_width_p = 16,
    parameter int b_width_p = 11
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           start_i,
    input  logic [a_width_p-1:0]           a_i,
    input  logic [b_width_p-1:0]           b_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [a_width_p+b_width_p-1:0] prod_o
);

    localparam int pw_lp = a_width_p + b_width_p;
    localparam int cw_lp = $clog2(b_width_p + 1);

    logic [pw_lp-1:0]     acc_q, acc_d, a_q, a_d;
    logic [b_width_p-1:0] b_q, b_d;
    logic [cw_lp-1:0]     left_q, left_d;
    logic                 busy_q, busy_d, done_q, done_d;

    // one multiplier bit per cycle, LSB first
    always_comb begin
        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        left_d = left_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_i) begin
            acc_d  = b_i[0] ? pw_lp'(a_i) : '0;
            a_d    = pw_lp'(a_i) << 1;
            b_d    = b_i >> 1;
            left_d = cw_lp'(b_width_p - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d  = acc_q + (b_q[0] ? a_q : '0);
            a_d    = a_q << 1;
            b_d    = b_q >> 1;
            left_d = left_q - cw_lp'(1);
            if (left_q == cw_lp'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // datapath and control registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            left_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_q    <= a_d;
            b_q    <= b_d;
            left_q <= left_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign prod_o = acc_q;

endmodule

// File: rtl/bsg_activation_backward.sv
// Backward pass of tanh/sigmoid: grad_o = g * f'(y).
// Optional BSG_ACTIVATION_BWD_ZERO_BYPASS_EN skips work on zero operands.
module bsg_activation_backward
    import bsg_activation_pkg::*;
#(
    parameter int precision_p  = 10,
    parameter int grad_width_p = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic signed [precision_p:0]    y_i,
    input  logic signed [grad_width_p-1:0] grad_i,
    input  logic                           tanh_sel_i,
    input  logic                           v_i,
    output logic                           ready_o,
    output logic signed [grad_width_p-1:0] grad_o,
    output logic                           v_o,
    input  logic                           ready_i
);

    localparam int yw_lp = precision_p + 1;
    localparam int pw_lp = grad_width_p + yw_lp;
    localparam int cw_lp = $clog2(yw_lp + 1);
    localparam logic [yw_lp-1:0] one_lp = {1'b1, {precision_p{1'b0}}};
    localparam logic [cw_lp-1:0] sq_last_lp = cw_lp'(yw_lp);
    localparam logic [cw_lp-1:0] scale_last_lp = cw_lp'(precision_p);

    bsg_act_bwd_state_e state_q, state_d;

    logic [yw_lp-1:0]        y_abs, y_clamp, ya_q, sq, d;
    logic [grad_width_p-1:0] g_q, g_abs, r, res, grad_q, grad_d;
    bsg_act_sel_e            sel_q;
    logic [pw_lp-1:0]        prod;
    logic [cw_lp-1:0]        cnt;
    logic                    accept, mul_start, mul_busy, mul_done;
    logic [grad_width_p-1:0] mul_a;
    logic [yw_lp-1:0]        mul_b;
    logic                    g_zero_skip, d_zero_skip;
    logic                    unused_prod;

    assign y_abs = y_i[precision_p] ? $unsigned(-y_i) : $unsigned(y_i);

    // clamp y into the derivative's valid domain before latching
    always_comb begin
        y_clamp = y_abs;
        if (tanh_sel_i) begin
            if (y_abs > one_lp) y_clamp = one_lp;
        end else if (y_i[precision_p]) begin
            y_clamp = '0;
        end else if (y_abs > one_lp) begin
            y_clamp = one_lp;
        end
    end

    assign g_abs = g_q[grad_width_p-1] ? $unsigned(-g_q) : $unsigned(g_q);
    assign sq    = prod[precision_p +: yw_lp];
    assign d     = (sel_q == e_tanh) ? one_lp - sq : ya_q - sq;
    assign r     = prod[precision_p +: grad_width_p];
    assign res   = g_q[grad_width_p-1] ? -r : r;
    assign unused_prod = ^{prod[pw_lp-1], prod[precision_p-1:0]};

`ifdef BSG_ACTIVATION_BWD_ZERO_BYPASS_EN
    assign g_zero_skip = (grad_i == '0);
    assign d_zero_skip = (d == '0);
`else
    assign g_zero_skip = 1'b0;
    assign d_zero_skip = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            e_IDLE:  if (v_i) state_d = g_zero_skip ? e_DONE : e_SQ;
            e_SQ:    if (cnt == sq_last_lp && !mul_busy) state_d = e_DERIV;
            e_DERIV: state_d = d_zero_skip ? e_DONE : e_SCALE;
            e_SCALE: if (cnt == scale_last_lp && mul_done) state_d = e_DONE;
            e_DONE:  if (ready_i) state_d = e_IDLE;
            default: state_d = e_IDLE;
        endcase
    end

    // FSM outputs and control strobes
    always_comb begin
        ready_o   = (state_q == e_IDLE);
        v_o       = (state_q == e_DONE);
        accept    = ready_o & v_i;
        mul_start = (accept & ~g_zero_skip)
                  | ((state_q == e_DERIV) & ~d_zero_skip);
        mul_a     = (state_q == e_IDLE) ? grad_width_p'(y_clamp) : g_abs;
        mul_b     = (state_q == e_IDLE) ? y_clamp : d;
        grad_d    = (state_q == e_SCALE) ? res : '0;
    end

    // operand capture at accept, result capture on DONE entry
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ya_q   <= '0;
            g_q    <= '0;
            sel_q  <= e_sigmoid;
            grad_q <= '0;
        end else begin
            if (accept) begin
                ya_q  <= y_clamp;
                g_q   <= grad_i;
                sel_q <= bsg_act_sel_e'(tanh_sel_i);
            end
            if (state_d == e_DONE && state_q != e_DONE) begin
                grad_q <= grad_d;
            end
        end
    end

    assign grad_o = grad_q;

    bsg_counter_clear_up #(
        .max_val_p(yw_lp)
    ) u_cnt (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clear_i  (accept | (state_q == e_DERIV)),
        .up_i     ((state_q == e_SQ) | (state_q == e_SCALE)),
        .count_o  (cnt)
    );

    bsg_mul_iter_shift_add #(
        .a_width_p(grad_width_p),
        .b_width_p(yw_lp)
    ) u_mul (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .start_i  (mul_start),
        .a_i      (mul_a),
        .b_i      (mul_b),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .prod_o   (prod)
    );

endmodule
